// File: rtl/pomodoro_pkg.sv
// pomodoro_pkg: state encoding, display constants and BCD helpers shared by the Pomodoro timer
package pomodoro_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2, DONE = 2'd3} state_t;
  localparam logic [63:0] DIG_SEL = {8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};
  localparam logic [79:0] SEG_LUT = {8'h90, 8'h80, 8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0};
  function automatic logic [7:0] bcd_to_seg(input logic [3:0] d);
    return d > 4'd9 ? 8'hFF : SEG_LUT[{d, 3'b000} +: 8];
  endfunction
  function automatic logic [15:0] sec_to_bcd(input int s);
    return {4'((s / 60) / 10), 4'((s / 60) % 10), 4'((s % 60) / 10), 4'((s % 60) % 10)};
  endfunction
endpackage

// File: rtl/pomodoro_countdown_ctrl_disp_scan.sv
// pomodoro_disp_scan: streams eight BCD digits (i_nib, digit k at [4k+:4]) as {seg, digit-select} words on o_dat/o_vld/i_rdy
module pomodoro_disp_scan
  import pomodoro_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] i_nib,
  input  logic        i_rdy,
  output logic [15:0] o_dat,
  output logic        o_vld
);
  logic [2:0]  r_idx;
  logic        r_vld;
  logic [15:0] r_dat;
  logic [2:0]  w_idx;
  logic [7:0]  w_seg;
  assign w_idx = r_vld ? r_idx + 3'd1 : r_idx;
  assign w_seg = bcd_to_seg(i_nib[{w_idx, 2'b00} +: 4]) & (w_idx == 3'd5 ? 8'h7F : 8'hFF);
  assign o_dat = r_dat;
  assign o_vld = r_vld;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx <= '0;
      r_vld <= 1'b0;
      r_dat <= '0;
    end else if (!r_vld || i_rdy) begin
      r_idx <= w_idx;
      r_vld <= 1'b1;
      r_dat <= {w_seg, DIG_SEL[{w_idx, 3'b000} +: 8]};
    end
  end
endmodule

// File: rtl/pomodoro_countdown_ctrl.sv
// pomodoro_countdown_ctrl: BCD mm:ss countdown with IDLE/RUN/PAUSE/DONE control, session counter and 7-seg scan stream (disp_dat/disp_vld/disp_rdy)
module pomodoro_countdown_ctrl
  import pomodoro_pkg::*;
#(
  parameter int                         TICK_DIV    = 125000000,
  parameter int                         NUM_PRESETS = 4,
  parameter logic [NUM_PRESETS*13-1:0]  PRESET_SEC  = {13'd3000, 13'd1500, 13'd600, 13'd300},
  parameter int                         SESS_DIGITS = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_PRESETS-1:0] btn_preset,
  input  logic                   btn_pause,
  input  logic                   btn_clr,
  output logic [15:0]            disp_dat,
  output logic                   disp_vld,
  input  logic                   disp_rdy,
  output logic                   alarm,
  output logic                   done_pulse,
  output logic [1:0]             state_o
);
  localparam int PW = $clog2(TICK_DIV);
  if (TICK_DIV < 2 || NUM_PRESETS < 1 || NUM_PRESETS > 8 || SESS_DIGITS < 1 || SESS_DIGITS > 4) begin : g_bad_param
    $error("pomodoro_countdown_ctrl: parameter out of range");
  end
  logic [15:0] w_preset_bcd [NUM_PRESETS];
  for (genvar p = 0; p < NUM_PRESETS; p++) begin : g_pre
    localparam int SEC = int'(PRESET_SEC[p*13 +: 13]);
    if (SEC < 1 || SEC > 5999) begin : g_bad_sec
      $error("pomodoro_countdown_ctrl: preset duration out of range");
    end
    assign w_preset_bcd[p] = sec_to_bcd(SEC);
  end
  state_t                 r_state;
  logic [NUM_PRESETS-1:0] r_btn_q;
  logic                   r_pause_q, r_clr_q, r_alarm, r_done;
  logic [15:0]            r_time, r_sess;
  logic [PW-1:0]          r_pre;
  logic [NUM_PRESETS-1:0] w_pre_edge;
  logic                   w_pause_edge, w_clr_edge, w_tick, w_cy;
  logic                   w_so0, w_st0, w_mo0;
  logic [15:0]            w_pre_bcd, w_dec, w_sess_inc;
  assign w_pre_edge   = btn_preset & ~r_btn_q;
  assign w_pause_edge = btn_pause & ~r_pause_q;
  assign w_clr_edge   = btn_clr & ~r_clr_q;
  assign w_tick       = r_state == RUN && r_pre == PW'(TICK_DIV - 1);
  // walk downward so the lowest-index simultaneous press wins
  always_comb begin
    w_pre_bcd = '0;
    for (int i = NUM_PRESETS - 1; i >= 0; i--) w_pre_bcd = w_pre_edge[i] ? w_preset_bcd[i] : w_pre_bcd;
  end
  assign w_so0 = r_time[3:0] == 4'd0;
  assign w_st0 = r_time[7:4] == 4'd0;
  assign w_mo0 = r_time[11:8] == 4'd0;
  assign w_dec[3:0]   = w_so0 ? 4'd9 : r_time[3:0] - 4'd1;
  assign w_dec[7:4]   = !w_so0 ? r_time[7:4] : w_st0 ? 4'd5 : r_time[7:4] - 4'd1;
  assign w_dec[11:8]  = !(w_so0 && w_st0) ? r_time[11:8] : w_mo0 ? 4'd9 : r_time[11:8] - 4'd1;
  assign w_dec[15:12] = !(w_so0 && w_st0 && w_mo0) ? r_time[15:12] : r_time[15:12] - 4'd1;
  // digits above SESS_DIGITS never increment, so they read as 0
  always_comb begin
    w_sess_inc = r_sess;
    w_cy = 1'b1;
    for (int i = 0; i < SESS_DIGITS; i++) begin
      w_sess_inc[i*4 +: 4] = !w_cy ? r_sess[i*4 +: 4] : r_sess[i*4 +: 4] == 4'd9 ? 4'd0 : r_sess[i*4 +: 4] + 4'd1;
      w_cy = w_cy && r_sess[i*4 +: 4] == 4'd9;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_btn_q   <= '0;
      r_pause_q <= 1'b0;
      r_clr_q   <= 1'b0;
      r_state   <= IDLE;
      r_time    <= '0;
      r_sess    <= '0;
      r_pre     <= '0;
      r_alarm   <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_btn_q   <= btn_preset;
      r_pause_q <= btn_pause;
      r_clr_q   <= btn_clr;
      r_done    <= 1'b0;
      if (w_clr_edge) begin
        r_state <= IDLE;
        r_time  <= '0;
        r_pre   <= '0;
        r_alarm <= 1'b0;
      end else if (|w_pre_edge) begin
        r_state <= RUN;
        r_time  <= w_pre_bcd;
        r_pre   <= '0;
        r_alarm <= 1'b0;
      end else if (w_pause_edge && (r_state == RUN || r_state == PAUSE)) begin
        r_state <= r_state == RUN ? PAUSE : RUN;
      end else if (r_state == RUN) begin
        r_pre  <= w_tick ? '0 : r_pre + PW'(1);
        r_time <= w_tick ? w_dec : r_time;
        if (w_tick && r_time == 16'h0001) begin
          r_state <= DONE;
          r_sess  <= w_sess_inc;
          r_done  <= 1'b1;
          r_alarm <= 1'b1;
        end
      end
    end
  end
  assign alarm      = r_alarm;
  assign done_pulse = r_done;
  assign state_o    = r_state;
  pomodoro_disp_scan u_scan (
    .clk   (clk),
    .rst_n (rst_n),
    .i_nib ({r_time[3:0], r_time[7:4], r_time[11:8], r_time[15:12],
             r_sess[3:0], r_sess[7:4], r_sess[11:8], r_sess[15:12]}),
    .i_rdy (disp_rdy),
    .o_dat (disp_dat),
    .o_vld (disp_vld)
  );
endmodule

// File: tb/tb_pomodoro_countdown_ctrl.sv
// tb_pomodoro_countdown_ctrl: directed self-checking bench for pomodoro_countdown_ctrl
module tb_pomodoro_countdown_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [3:0]  btn_preset = '0;
  logic        btn_pause = 1'b0, btn_clr = 1'b0, disp_rdy = 1'b0;
  logic [15:0] disp_dat;
  logic        disp_vld, alarm, done_pulse;
  logic [1:0]  state_o;
  int          n_run = 0, n_fail = 0, exp_sess = 0;
  logic [63:0] segs;
  logic [7:0]  seg_tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
  pomodoro_countdown_ctrl #(
    .TICK_DIV    (4),
    .NUM_PRESETS (4),
    .PRESET_SEC  ({13'd1, 13'd125, 13'd61, 13'd3}),
    .SESS_DIGITS (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_preset (btn_preset),
    .btn_pause  (btn_pause),
    .btn_clr    (btn_clr),
    .disp_dat   (disp_dat),
    .disp_vld   (disp_vld),
    .disp_rdy   (disp_rdy),
    .alarm      (alarm),
    .done_pulse (done_pulse),
    .state_o    (state_o)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic press_preset(input logic [3:0] m);
    btn_preset = m;
    step(1);
    btn_preset = '0;
  endtask
  task automatic toggle_pause();
    btn_pause = 1'b1;
    step(1);
    btn_pause = 1'b0;
  endtask
  task automatic press_clr();
    btn_clr = 1'b1;
    step(1);
    btn_clr = 1'b0;
  endtask
  task automatic read_disp(output logic [63:0] s);
    s = '0;
    disp_rdy = 1'b1;
    step(8);
    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < 8; k++) if (disp_vld && disp_dat[k]) s[k*8 +: 8] = disp_dat[15:8];
      step(1);
    end
  endtask
  function automatic logic [15:0] to_bcd(input int n);
    return {4'(n / 1000 % 10), 4'(n / 100 % 10), 4'(n / 10 % 10), 4'(n % 10)};
  endfunction
  function automatic logic [63:0] exp_disp(input logic [15:0] sess, input logic [15:0] t);
    logic [63:0] r;
    logic [3:0]  n;
    r = '0;
    for (int k = 0; k < 8; k++) begin
      n = k < 4 ? sess[(3 - k) * 4 +: 4] : t[(7 - k) * 4 +: 4];
      r[k*8 +: 8] = seg_tab[n];
      if (k == 5) r[k*8 + 7] = 1'b0;
    end
    return r;
  endfunction
  initial begin
    #1 rst_n = 1'b0;
    #1;
    check("rst_state", state_o, 0);
    check("rst_vld", disp_vld, 0);
    check("rst_dat", disp_dat, 0);
    check("rst_alarm", alarm, 0);
    check("rst_done", done_pulse, 0);
    step(2);
    rst_n = 1'b1;
    step(1);
    check("first_vld", disp_vld, 1);
    check("first_word", disp_dat, 16'hC001);
    step(10);
    check("stall_word", disp_dat, 16'hC001);
    check("stall_vld", disp_vld, 1);
    disp_rdy = 1'b1;
    for (int k = 0; k < 9; k++) begin
      check("scan_sel", disp_dat[7:0], 8'(1) << (k % 8));
      if (k == 5) check("colon_dp", disp_dat[15], 0);
      step(1);
    end
    press_preset(4'b0001);
    check("a_run", state_o, 1);
    toggle_pause();
    check("a_pause", state_o, 2);
    read_disp(segs);
    check("a_load", segs, exp_disp(16'h0000, 16'h0003));
    toggle_pause();
    check("a_resume", state_o, 1);
    step(11);
    check("a_pre_state", state_o, 1);
    check("a_pre_done", done_pulse, 0);
    step(1);
    check("a_done_state", state_o, 3);
    check("a_done_pulse", done_pulse, 1);
    check("a_alarm", alarm, 1);
    step(1);
    check("a_pulse_once", done_pulse, 0);
    check("a_alarm_hold", alarm, 1);
    exp_sess = 1;
    toggle_pause();
    check("a_pause_ign", state_o, 3);
    read_disp(segs);
    check("a_disp_done", segs, exp_disp(to_bcd(exp_sess), 16'h0000));
    press_preset(4'b0010);
    check("b_run", state_o, 1);
    check("b_alarm_off", alarm, 0);
    step(8);
    toggle_pause();
    read_disp(segs);
    check("b_borrow", segs, exp_disp(to_bcd(exp_sess), 16'h0059));
    toggle_pause();
    step(6);
    toggle_pause();
    step(40);
    read_disp(segs);
    check("b_frozen", segs, exp_disp(to_bcd(exp_sess), 16'h0058));
    toggle_pause();
    step(1);
    toggle_pause();
    read_disp(segs);
    check("b_no_early", segs, exp_disp(to_bcd(exp_sess), 16'h0058));
    toggle_pause();
    step(1);
    toggle_pause();
    read_disp(segs);
    check("b_remain", segs, exp_disp(to_bcd(exp_sess), 16'h0057));
    toggle_pause();
    check("c_run", state_o, 1);
    btn_clr = 1'b1;
    btn_preset = 4'b0001;
    step(1);
    btn_clr = 1'b0;
    btn_preset = '0;
    check("c_clr_wins", state_o, 0);
    read_disp(segs);
    check("c_clr_disp", segs, exp_disp(to_bcd(exp_sess), 16'h0000));
    toggle_pause();
    check("c_pause_idle", state_o, 0);
    press_preset(4'b0110);
    check("c_multi_run", state_o, 1);
    toggle_pause();
    read_disp(segs);
    check("c_low_idx", segs, exp_disp(to_bcd(exp_sess), 16'h0101));
    press_clr();
    check("c_clr_pause", state_o, 0);
    while (exp_sess < 9999) begin
      press_preset(4'b1000);
      step(4);
      exp_sess++;
    end
    check("d_done_state", state_o, 3);
    read_disp(segs);
    check("d_9999", segs, exp_disp(to_bcd(exp_sess), 16'h0000));
    press_preset(4'b1000);
    check("d_restart", state_o, 1);
    check("d_alarm_off", alarm, 0);
    step(3);
    check("d_pre_pulse", done_pulse, 0);
    step(1);
    check("d_pulse", done_pulse, 1);
    exp_sess = (exp_sess + 1) % 10000;
    read_disp(segs);
    check("d_wrap", segs, exp_disp(to_bcd(exp_sess), 16'h0000));
    press_preset(4'b0100);
    check("f_run", state_o, 1);
    step(3);
    #2 rst_n = 1'b0;
    #1;
    check("f_state", state_o, 0);
    check("f_vld", disp_vld, 0);
    check("f_dat", disp_dat, 0);
    check("f_alarm", alarm, 0);
    check("f_done", done_pulse, 0);
    @(posedge clk);
    #1;
    check("f_vld_hold", disp_vld, 0);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("f_first_vld", disp_vld, 1);
    check("f_first_word", disp_dat, 16'hC001);
    check("f_idle", state_o, 0);
    read_disp(segs);
    check("f_cleared", segs, exp_disp(16'h0000, 16'h0000));
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
